// File: rtl/seg_pipe_adder.sv
// seg_pipe_adder: WIDTH-bit add/sub whose carry chain is cut into
// SEG_W-bit registered segments, with a global valid/ready stall.
module seg_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG_W;

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
  } stage_t;

  stage_t           st_q [NSEG];
  stage_t           st_d [NSEG];
  logic [SEG_W:0]   seg_sum [NSEG];
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             advance;
  stage_t           last;

  assign last     = st_q[NSEG-1];
  assign advance  = !last.valid || out_ready;
  assign in_ready = advance;

  // Subtract folds into an add of ~b with a forced carry-in.
  assign b_eff = sub ? ~b : b;
  assign c0    = sub | cin;

  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      st_d[k]    = st_q[k];
      seg_sum[k] = '0;
    end
    if (advance) begin
      seg_sum[0] = {1'b0, a[SEG_W-1:0]}
                 + {1'b0, b_eff[SEG_W-1:0]}
                 + {{SEG_W{1'b0}}, c0};
      st_d[0].valid = in_valid;
      st_d[0].carry = seg_sum[0][SEG_W];
      st_d[0].sa    = a[WIDTH-1];
      st_d[0].sb    = b_eff[WIDTH-1];
      st_d[0].opa   = a;
      st_d[0].opb   = b_eff;
      st_d[0].res   = '0;
      st_d[0].res[SEG_W-1:0] = seg_sum[0][SEG_W-1:0];
      for (int k = 1; k < NSEG; k++) begin
        seg_sum[k] = {1'b0, st_q[k-1].opa[k*SEG_W +: SEG_W]}
                   + {1'b0, st_q[k-1].opb[k*SEG_W +: SEG_W]}
                   + {{SEG_W{1'b0}}, st_q[k-1].carry};
        st_d[k]       = st_q[k-1];
        st_d[k].carry = seg_sum[k][SEG_W];
        st_d[k].res[k*SEG_W +: SEG_W] = seg_sum[k][SEG_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        st_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

  assign out_valid = last.valid;
  assign sum       = last.res;
  assign cout      = last.carry;
  assign ovf       = (last.sa == last.sb) &&
                     (last.res[WIDTH-1] != last.sa);

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Bench for seg_pipe_adder: three configs (32/8, 8/8, 16/4) checked
// against an arithmetic model plus directed literal expectations.
module tb_seg_pipe_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        lit;
    logic [31:0] lsum;
    logic        lco;
    logic        lov;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int          wd [3];
  logic [2:0]  iv, ir, ov, ordy, ci, sb, co, of;
  logic [31:0] a_l [3];
  logic [31:0] b_l [3];
  logic [31:0] sum_l [3];
  logic [31:0] sum0;
  logic [7:0]  sum1;
  logic [15:0] sum2;

  logic [2:0]  lit_v, lit_c, lit_o;
  logic [31:0] lit_s [3];

  assign sum_l[0] = sum0;
  assign sum_l[1] = {24'h0, sum1};
  assign sum_l[2] = {16'h0, sum2};

  seg_pipe_adder #(.WIDTH(32), .SEG_W(8)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_l[0]), .b(b_l[0]), .cin(ci[0]), .sub(sb[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .sum(sum0), .cout(co[0]), .ovf(of[0]));

  seg_pipe_adder #(.WIDTH(8), .SEG_W(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_l[1][7:0]), .b(b_l[1][7:0]), .cin(ci[1]), .sub(sb[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .sum(sum1), .cout(co[1]), .ovf(of[1]));

  seg_pipe_adder #(.WIDTH(16), .SEG_W(4)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_l[2][15:0]), .b(b_l[2][15:0]), .cin(ci[2]), .sub(sb[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .sum(sum2), .cout(co[2]), .ovf(of[2]));

  // Reference: {cout,sum} = A + B_eff + c over w bits.
  function automatic ent_t model(int w, logic [31:0] x, logic [31:0] y,
                                 logic c, logic s);
    logic [31:0] m, xa, be;
    logic [32:0] full;
    ent_t e;
    m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    xa   = x & m;
    be   = (s ? ~y : y) & m;
    full = {1'b0, xa} + {1'b0, be} + {32'd0, (s | c)};
    e      = '0;
    e.sum  = full[31:0] & m;
    e.cout = full[w];
    e.ovf  = (xa[w-1] == be[w-1]) && (e.sum[w-1] != xa[w-1]);
    return e;
  endfunction

  ent_t        fifo [3][64];
  int          wp [3], rp [3], acc [3], got [3];
  logic [2:0]  stl, hc, ho;
  logic [31:0] hs [3];
  int          tests = 0;
  int          fails = 0;
  logic        end_req = 1'b0;
  logic        end_done = 1'b0;

  always @(negedge clk) begin
    ent_t e;
    if (end_req && !end_done) begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (wp[i] != rp[i]) begin
          fails++;
          $display("FAIL lane%0d drain: %0d results pending, want 0",
                   i, wp[i] - rp[i]);
        end
        tests++;
        if (got[i] != acc[i]) begin
          fails++;
          $display("FAIL lane%0d count: got %0d results, want %0d",
                   i, got[i], acc[i]);
        end
      end
      end_done = 1'b1;
    end else if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (ov[i] !== 1'b0 || sum_l[i] !== 32'h0 || co[i] !== 1'b0 ||
            of[i] !== 1'b0 || ir[i] !== 1'b1) begin
          fails++;
          $display("FAIL lane%0d reset: ov=%b sum=%h co=%b of=%b ir=%b, want 0 0 0 0 1",
                   i, ov[i], sum_l[i], co[i], of[i], ir[i]);
        end
        wp[i] = 0; rp[i] = 0; acc[i] = 0; got[i] = 0;
        stl[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (ir[i] !== !(ov[i] && !ordy[i])) begin
          fails++;
          $display("FAIL lane%0d in_ready: got %b, want %b",
                   i, ir[i], !(ov[i] && !ordy[i]));
        end
        if (stl[i]) begin
          tests++;
          if (ov[i] !== 1'b1 || sum_l[i] !== hs[i] ||
              co[i] !== hc[i] || of[i] !== ho[i]) begin
            fails++;
            $display("FAIL lane%0d hold: got v=%b %h/%b/%b, want v=1 %h/%b/%b",
                     i, ov[i], sum_l[i], co[i], of[i], hs[i], hc[i], ho[i]);
          end
        end
        if (iv[i] && ir[i]) begin
          e      = model(wd[i], a_l[i], b_l[i], ci[i], sb[i]);
          e.lit  = lit_v[i];
          e.lsum = lit_s[i];
          e.lco  = lit_c[i];
          e.lov  = lit_o[i];
          fifo[i][wp[i] % 64] = e;
          wp[i]++;
          acc[i]++;
        end
        if (ov[i]) begin
          tests++;
          if (wp[i] == rp[i]) begin
            fails++;
            $display("FAIL lane%0d stale: out_valid=1 sum=%h, want no result",
                     i, sum_l[i]);
          end else begin
            e = fifo[i][rp[i] % 64];
            if ({sum_l[i], co[i], of[i]} !== {e.sum, e.cout, e.ovf}) begin
              fails++;
              $display("FAIL lane%0d result: got %h/%b/%b, want %h/%b/%b",
                       i, sum_l[i], co[i], of[i], e.sum, e.cout, e.ovf);
            end
            if (e.lit) begin
              tests++;
              if ({sum_l[i], co[i], of[i]} !== {e.lsum, e.lco, e.lov}) begin
                fails++;
                $display("FAIL lane%0d literal: got %h/%b/%b, want %h/%b/%b",
                         i, sum_l[i], co[i], of[i], e.lsum, e.lco, e.lov);
              end
            end
            if (ordy[i]) begin
              rp[i]++;
              got[i]++;
            end
          end
        end
        stl[i] = ov[i] && !ordy[i];
        hs[i]  = sum_l[i];
        hc[i]  = co[i];
        ho[i]  = of[i];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // One beat with a literal expectation; out_ready is held high here.
  task automatic put(int i, logic [31:0] x, logic [31:0] y, logic c,
                     logic s, logic [31:0] es, logic ec, logic eo);
    iv[i] = 1'b1; a_l[i] = x; b_l[i] = y; ci[i] = c; sb[i] = s;
    lit_v[i] = 1'b1; lit_s[i] = es; lit_c[i] = ec; lit_o[i] = eo;
    tick();
    iv[i] = 1'b0;
    lit_v[i] = 1'b0;
  endtask

  function automatic logic [31:0] rnd(int w);
    logic [31:0] m, r;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r = 32'h0;
      1: r = m;
      2: r = 32'd1 << (w - 1);
      3: r = (32'd1 << (w - 1)) - 32'd1;
      default: r = $urandom;
    endcase
    return r & m;
  endfunction

  initial begin
    int   idx, cyc, n0;
    logic [2:0] took;
    wd[0] = 32; wd[1] = 8; wd[2] = 16;
    iv = '0; ordy = '1; ci = '0; sb = '0;
    lit_v = '0; lit_c = '0; lit_o = '0;
    for (int i = 0; i < 3; i++) begin
      a_l[i] = '0; b_l[i] = '0; lit_s[i] = '0;
    end

    #2 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    put(0, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
    put(0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    put(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    put(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    put(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    put(0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    put(0, 32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    put(1, 32'hFF, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0);
    put(1, 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1);
    put(1, 32'h10, 32'h20, 1'b0, 1'b1, 32'hF0, 1'b0, 1'b0);
    put(2, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0);
    put(2, 32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1);
    put(2, 32'h0FFF, 32'h0001, 1'b1, 1'b0, 32'h1001, 1'b0, 1'b0);
    idle(8);

    // Backpressure on lane 0 with out_ready cycling 1,0,0,1.
    idx = 0;
    cyc = 0;
    while ((idx < 8 || cyc < 40) && cyc < 200) begin
      ordy[0] = (cyc % 4 == 0) || (cyc % 4 == 3);
      iv[0]   = (idx < 8);
      a_l[0]  = 32'h0123_4567 * (idx + 1);
      b_l[0]  = 32'h89AB_CDEF ^ idx;
      ci[0]   = idx[1];
      sb[0]   = idx[0];
      @(negedge clk);
      if (iv[0] && ir[0]) idx++;
      tick();
      cyc++;
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    idle(8);

    // Reset with three beats in flight on lane 0.
    put(0, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 32'h3333_3333, 1'b0, 1'b0);
    put(0, 32'h4444_4444, 32'h1111_1111, 1'b0, 1'b1, 32'h3333_3333, 1'b1, 1'b0);
    put(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(10);

    // Random traffic on all three configs at once.
    n0 = 0;
    took = '0;
    for (int c = 0; c < 30000 && n0 < 10000; c++) begin
      @(negedge clk);
      took = iv & ir;
      if (took[0]) n0++;
      tick();
      for (int i = 0; i < 3; i++) begin
        ordy[i] = ($urandom_range(0, 9) < 7);
        if (!iv[i] || took[i]) begin
          iv[i]  = ($urandom_range(0, 9) < 7);
          a_l[i] = rnd(wd[i]);
          b_l[i] = rnd(wd[i]);
          ci[i]  = $urandom_range(0, 1) == 1;
          sb[i]  = $urandom_range(0, 1) == 1;
        end
      end
    end
    iv = '0;
    ordy = '1;
    idle(20);

    end_req = 1'b1;
    for (int n = 0; n < 5 && !end_done; n++) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_pipe_adder.md
# seg_pipe_adder

Parametrised, pipelined two's-complement adder/subtractor built from carry-propagate segments, one segment per pipeline stage. It generalises the single-bit full adder to WIDTH bits and splits the carry chain into NSEG = WIDTH/SEG_W registered stages, which shortens the critical path. A valid/ready handshake and a per-operation add/sub mode let it sit between streaming datapath blocks, which can stall it.

## Interface
- WIDTH, default 32: operand and result width in bits; must be a multiple of SEG_W and at least SEG_W.
- SEG_W, default 8: bits resolved per pipeline stage; NSEG = WIDTH/SEG_W stages.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0: A+B+cin; 1: A-B, computed as A+~B+1 with cin ignored.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1. For sub, 1 means no borrow (A>=B unsigned).
- ovf  out  1  signed overflow of the add or subtract.

## Operation
- Stages S0..S(NSEG-1). Each stage holds:
  - a valid bit;
  - the completed low result bits;
  - the carry into the next segment;
  - the not-yet-added upper operand bits, with B already inverted when sub=1;
  - the sign bits needed for ovf.
- S0 adds segment 0 (bits SEG_W-1:0) at the accept edge. Sk adds segment k using the carry registered in S(k-1).
- The last stage drives sum, cout and ovf directly from registers; there is no combinational path from a, b or cin to the outputs.
- ovf = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]), where b_eff = sub ? ~b : b.
- Global stall: advance = !out_valid || out_ready; in_ready = advance.
  - advance=1: every stage shifts one position.
  - advance=0: every stage holds, including valid bits and data.
- Transfer in: in_valid && in_ready loads S0 with valid=1. in_valid=0 while advance=1 loads a bubble (valid=0).
- Transfer out: out_valid && out_ready.
- Bubbles are not compressed: an empty stage still costs one cycle.
- Data registers of invalid stages are don't-care. The bench checks sum, cout and ovf only while out_valid=1.
- Results leave in strict acceptance order; no reordering.
- NSEG=1 (SEG_W=WIDTH) is legal: a single registered full-width adder.

## Timing
- Reset (rst_n=0, asynchronous): all valid bits go to 0 immediately.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 as soon as reset is applied (out_valid=0).
- Reset mid-operation discards every in-flight beat; no partial result is emitted after release.
- Latency: a beat accepted at edge t gives out_valid=1 with its result after edge t+NSEG-1, if no stall occurs in between. Default config: 4 cycles.
- Throughput: one beat per cycle while out_ready=1.
- Stall: with out_valid=1 and out_ready=0:
  - sum, cout, ovf and out_valid are held stable;
  - in_ready=0 in the same cycle.
  - A beat presented on a, b, cin and sub is not consumed and must be held by the source.
- Simultaneous events: if out_ready rises, the output transfer and a new input acceptance happen on the same edge.
- in_ready depends combinationally on out_ready and out_valid only. in_valid may depend on in_ready.

## Test plan
- Reset and pipeline fill:
  - hold rst_n=0 -> out_valid=0, sum=0, in_ready=1;
  - release, then stream A=0x00000001,B=0x00000002 and A=0x0000FFFF,B=0x00000001 back-to-back -> after 4 cycles sum=0x00000003, then 0x00010000, with cout=0 and ovf=0.
- Full carry ripple across all segments:
  - A=0xFFFFFFFF, B=0, cin=1 -> sum=0x00000000, cout=1, ovf=0;
  - A=0x7FFFFFFF, B=1 -> sum=0x80000000, ovf=1, cout=0.
- Subtract mode:
  - A=5, B=7, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0 (borrow), ovf=0; cin ignored;
  - A=0x80000000, B=1, sub=1 -> sum=0x7FFFFFFF, ovf=1, cout=1.
- Backpressure:
  - stream 8 beats with out_ready toggling 1,0,0,1… -> no beat lost or duplicated, order preserved;
  - outputs stable while stalled; in_ready=0 exactly when out_valid=1 and out_ready=0.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight -> out_valid falls immediately, and no stale result appears after release.
- Parameter sweep:
  - WIDTH=8,SEG_W=8 (NSEG=1) and WIDTH=16,SEG_W=4 (NSEG=4);
  - 10k random a, b, cin, sub with random in_valid and out_ready;
  - compare against a reference model of {cout,sum}=A+B_eff+c and the ovf formula.
